uart_cache_bridge: RTL and testbench

//  Upstream command stage for Cache. Parses a binary byte stream from the UART receiver into
//  32-bit cache read/write transactions, drives Cache address/data_in/write_enable, waits on

---
 rtl/bridge_pkg.sv | 21 ++
 rtl/uart_cache_bridge.sv | 182 ++++++++++++++++++
 tb/tb_uart_cache_bridge.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg
//   Shared constants and FSM state encoding for the UART-to-cache command
//   bridge: command/response byte codes and the bridge state enum.
package bridge_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_ADDR    = 3'd1,
    RX_DATA    = 3'd2,
    SETTLE     = 3'd3,
    WAIT_VALID = 3'd4,
    WRITE      = 3'd5,
    TX         = 3'd6
  } state_t;

endpackage

// File: rtl/uart_cache_bridge.sv
// uart_cache_bridge
//   Parses a binary byte stream from the UART receiver into 32-bit cache
//   read/write transactions and returns response bytes to the UART
//   transmitter.
//     'W' A0..A3 D0..D3 -> ACK 0x06
//     'R' A0..A3        -> D0..D3
//     unknown command / cache timeout -> NAK 0x15
//   Multi-byte fields are little-endian (first byte = bits 7:0).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rx_data, rx_valid        received byte and its one-cycle strobe
//   tx_data, tx_valid        byte to transmit, held until tx_ready
//   tx_ready                 transmitter accepts on tx_valid && tx_ready
//   address, data_in         cache address / write data
//   write_enable             one-cycle write strobe per write command
//   data_out, data_out_valid cache read data and its valid flag
//   busy                     high whenever the FSM is not IDLE
//   overrun                  sticky: a byte arrived while not receiving
module uart_cache_bridge
  import bridge_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic        write_enable,
  input  logic [31:0] data_out,
  input  logic        data_out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t         state;
  logic           is_write;
  logic [1:0]     byte_cnt;
  logic [31:0]    addr_shadow;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  wait_cnt;
  logic [31:0]    tx_shift;   // response bytes, current byte in [7:0]
  logic [1:0]     tx_cnt;
  logic [1:0]     tx_last;    // index of final response byte (0 or 3)

  // Outputs decode directly from registered state, so they only change
  // at clock edges and stay stable across a stalled handshake.
  assign tx_valid     = (state == TX);
  assign tx_data      = tx_shift[7:0];
  assign write_enable = (state == WRITE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= 2'd0;
      addr_shadow <= 32'd0;
      address     <= 32'd0;
      data_in     <= 32'd0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      tx_shift    <= 32'd0;
      tx_cnt      <= 2'd0;
      tx_last     <= 2'd0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
              is_write <= (rx_data == CMD_WRITE);
              byte_cnt <= 2'd0;
              state    <= RX_ADDR;
            end else begin
              tx_shift <= {24'd0, RSP_NAK};
              tx_cnt   <= 2'd0;
              tx_last  <= 2'd0;
              state    <= TX;
            end
          end
        end

        RX_ADDR: begin
          if (rx_valid) begin
            addr_shadow <= {rx_data, addr_shadow[31:8]};
            byte_cnt    <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= RX_DATA;
              end else begin
                // Present the address to the cache as SETTLE begins.
                address    <= {rx_data, addr_shadow[31:8]};
                settle_cnt <= '0;
                state      <= SETTLE;
              end
            end
          end
        end

        RX_DATA: begin
          if (rx_valid) begin
            data_in  <= {rx_data, data_in[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              address    <= addr_shadow;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end

        // data_out_valid may still describe the previous address here.
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            wait_cnt <= '0;
            state    <= WAIT_VALID;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        WAIT_VALID: begin
          if (data_out_valid) begin
            if (is_write) begin
              state <= WRITE;
            end else begin
              tx_shift <= data_out;
              tx_cnt   <= 2'd0;
              tx_last  <= 2'd3;
              state    <= TX;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            tx_shift <= {24'd0, RSP_NAK};
            tx_cnt   <= 2'd0;
            tx_last  <= 2'd0;
            state    <= TX;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WRITE: begin
          tx_shift <= {24'd0, RSP_ACK};
          tx_cnt   <= 2'd0;
          tx_last  <= 2'd0;
          state    <= TX;
        end

        TX: begin
          if (tx_ready) begin
            if (tx_cnt == tx_last) begin
              state <= IDLE;
            end else begin
              tx_shift <= tx_shift >> 8;
              tx_cnt   <= tx_cnt + 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Bytes arriving outside the receive states are dropped and flagged.
      if (rx_valid && state != IDLE && state != RX_ADDR && state != RX_DATA)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cache_bridge.sv
module tb_uart_cache_bridge;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic        overrun;

  uart_cache_bridge #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .address       (address),
    .data_in       (data_in),
    .write_enable  (write_enable),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // write_enable monitor: every high cycle counts as one pulse
  int          we_total = 0;
  logic [31:0] we_data  = 32'd0;
  logic [31:0] we_addr  = 32'd0;
  always @(negedge clk) begin
    if (write_enable) begin
      we_total = we_total + 1;
      we_data  = data_in;
      we_addr  = address;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Cycles until tx_valid first seen; -1 if the bound expires.
  task automatic run_until_tx(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (tx_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Drain four response bytes with tx_ready held high.
  task automatic read_word(output logic [31:0] w, output logic all_valid);
    all_valid = 1'b1;
    w = 32'd0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      all_valid = all_valid & tx_valid;
      w[8*i +: 8] = tx_data;
      tick();
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          lat;
  int          we_before;
  logic [31:0] w;
  logic        av;

  initial begin
    rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b0;
    data_out = 32'd0; data_out_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // 1: write 0x12345678 to 0x100, ACK SETTLE+2 cycles after last byte
    data_out_valid = 1'b1;
    we_before = we_total;
    send_byte(8'h57);
    send_word(32'h0000_0100);
    send_word(32'h1234_5678);
    run_until_tx(lat);
    check("w1_ack_latency", lat, 32'd4);
    check("w1_we_pulses", we_total - we_before, 32'd1);
    check("w1_we_data", we_data, 32'h1234_5678);
    check("w1_we_addr", we_addr, 32'h0000_0100);
    check("w1_ack", {24'd0, tx_data}, 32'h06);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("w1_done_txv", {31'd0, tx_valid}, 32'd0);
    check("w1_done_busy", {31'd0, busy}, 32'd0);
    check("w1_addr_hold", address, 32'h0000_0100);

    // 2: read 0x100, bytes in order, 5-cycle stall holds byte
    data_out = 32'h1234_5678;
    send_byte(8'h52);
    send_word(32'h0000_0100);
    run_until_tx(lat);
    check("r2_latency", lat, 32'd3);
    check("r2_b0", {24'd0, tx_data}, 32'h78);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("r2_b1", {24'd0, tx_data}, 32'h56);
    repeat (5) tick();
    check("r2_stall_txv", {31'd0, tx_valid}, 32'd1);
    check("r2_stall_b1", {24'd0, tx_data}, 32'h56);
    tx_ready = 1'b1; tick();
    check("r2_b2", {24'd0, tx_data}, 32'h34);
    tick();
    check("r2_b3", {24'd0, tx_data}, 32'h12);
    tick(); tx_ready = 1'b0;
    check("r2_done_busy", {31'd0, busy}, 32'd0);
    check("r2_done_txv", {31'd0, tx_valid}, 32'd0);

    // 3: valid only during SETTLE, then timeout after 16 wait cycles
    data_out_valid = 1'b1;
    send_byte(8'h52);
    send_word(32'h0000_0004);
    tick();
    data_out_valid = 1'b0;
    run_until_tx(lat);
    check("t3_nak_latency", lat + 1, 32'd18);
    check("t3_nak", {24'd0, tx_data}, 32'h15);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("t3_single_byte", {31'd0, tx_valid}, 32'd0);
    check("t3_idle", {31'd0, busy}, 32'd0);

    // 4: unknown byte gives NAK, next read works
    send_byte(8'h41);
    check("u4_txv", {31'd0, tx_valid}, 32'd1);
    check("u4_nak", {24'd0, tx_data}, 32'h15);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("u4_single", {31'd0, tx_valid}, 32'd0);
    data_out = 32'hCAFE_F00D;
    data_out_valid = 1'b1;
    send_byte(8'h52);
    send_word(32'h0000_0200);
    run_until_tx(lat);
    check("u4_latency", lat, 32'd3);
    read_word(w, av);
    check("u4_word", w, 32'hCAFE_F00D);
    check("u4_valid", {31'd0, av}, 32'd1);
    check("u4_addr", address, 32'h0000_0200);

    // 5: bytes during WAIT_VALID and TX are dropped, overrun set
    check("o5_before", {31'd0, overrun}, 32'd0);
    data_out_valid = 1'b0;
    data_out = 32'hA5A5_5A5A;
    send_byte(8'h52);
    send_word(32'h0000_0300);
    tick(); tick();
    check("o5_busy_wait", {31'd0, busy}, 32'd1);
    send_byte(8'h57);
    check("o5_overrun", {31'd0, overrun}, 32'd1);
    data_out_valid = 1'b1;
    run_until_tx(lat);
    check("o5_latency", lat, 32'd1);
    send_byte(8'h41);
    check("o5_tx_hold", {24'd0, tx_data}, 32'h5A);
    tx_ready = 1'b1;
    w = 32'd0;
    for (int i = 0; i < 3; i++) begin
      w[8*i +: 8] = tx_data;
      tick();
    end
    w[31:24] = tx_data;
    rx_data = 8'h52; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; tx_ready = 1'b0;
    check("o5_word", w, 32'hA5A5_5A5A);
    check("o5_drop_at_end", {31'd0, busy}, 32'd0);

    // 6: reset mid-frame discards it; following write works
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    we_before = we_total;
    rst = 1'b1; tick(); rst = 1'b0;
    check("r6_busy", {31'd0, busy}, 32'd0);
    check("r6_overrun", {31'd0, overrun}, 32'd0);
    check("r6_address", address, 32'd0);
    repeat (4) tick();
    check("r6_no_tx", {31'd0, tx_valid}, 32'd0);
    check("r6_no_we", we_total - we_before, 32'd0);
    data_out_valid = 1'b1;
    send_byte(8'h57);
    send_word(32'hFFFF_FFFC);
    send_word(32'hDEAD_BEEF);
    run_until_tx(lat);
    check("r6_ack_latency", lat, 32'd4);
    check("r6_we_pulses", we_total - we_before, 32'd1);
    check("r6_we_addr", we_addr, 32'hFFFF_FFFC);
    check("r6_we_data", we_data, 32'hDEAD_BEEF);
    check("r6_ack", {24'd0, tx_data}, 32'h06);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("r6_done", {31'd0, busy}, 32'd0);
    check("r6_overrun_end", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
